// File: rtl/l1_sdram_arbiter_pkg.sv
// Shared types for the L1 SDRAM arbiter: FSM state encoding and requester IDs.
package l1_sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    L1I = 1'b0,
    L1D = 1'b1
  } req_id_t;

endpackage

// File: rtl/l1_sdram_arbiter_rr_pick2.sv
// Combinational two-way pick: fixed data-side priority or round-robin against last_grant.
module rr_pick2 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant
);
  import l1_sdram_arbiter_pkg::*;

  always_comb begin
    grant = L1I;
    if (req_i && req_d) begin
      // On a tie, round-robin hands the bus to whoever did not have it last.
      grant = (FIXED_PRIO != 0) ? L1D : ~last_grant;
    end else if (req_d) begin
      grant = L1D;
    end
  end

endmodule

// File: rtl/l1_sdram_arbiter.sv
// Shares the SDRAM controller start/done bus between the l1i and l1d caches.
module l1_sdram_arbiter
  import l1_sdram_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] l1i_addr,
  input  logic [31:0]       l1i_data,
  input  logic              l1i_we,
  input  logic              l1i_start,
  output logic [31:0]       l1i_q,
  output logic              l1i_done,
  input  logic [ADDR_W-1:0] l1d_addr,
  input  logic [31:0]       l1d_data,
  input  logic              l1d_we,
  input  logic              l1d_start,
  output logic [31:0]       l1d_q,
  output logic              l1d_done,
  output logic [ADDR_W-1:0] sdc_addr,
  output logic [31:0]       sdc_data,
  output logic              sdc_we,
  output logic              sdc_start,
  input  logic [31:0]       sdc_q,
  input  logic              sdc_done,
  output logic              busy
);

  state_t  state, state_nx;
  req_id_t grant, last_grant, pick;
  logic    pick_raw;

  rr_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req_i      (l1i_start),
    .req_d      (l1d_start),
    .last_grant (last_grant),
    .grant      (pick_raw)
  );

  assign pick = req_id_t'(pick_raw);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (l1i_start || l1d_start) state_nx = BUSY;
      BUSY:    if (sdc_done) state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latches: frozen for the whole BUSY period regardless of requester inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= L1I;
      last_grant <= L1I;
      sdc_addr   <= '0;
      sdc_data   <= '0;
      sdc_we     <= 1'b0;
      sdc_start  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (l1i_start || l1d_start) begin
            grant      <= pick;
            last_grant <= pick;
            sdc_addr   <= (pick == L1D) ? l1d_addr : l1i_addr;
            sdc_data   <= (pick == L1D) ? l1d_data : l1i_data;
            sdc_we     <= (pick == L1D) ? l1d_we   : l1i_we;
            sdc_start  <= 1'b1;
          end
        end
        BUSY: begin
          if (sdc_done) begin
            sdc_start <= 1'b0;
            sdc_we    <= 1'b0;
            sdc_data  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // A requester that dropped start mid-transaction gets no done pulse.
  always_comb begin
    busy     = (state == BUSY);
    l1i_q    = sdc_q;
    l1d_q    = sdc_q;
    l1i_done = (state == BUSY) && sdc_done && (grant == L1I) && l1i_start;
    l1d_done = (state == BUSY) && sdc_done && (grant == L1D) && l1d_start;
  end

endmodule
